rx_frame_parser: RTL and testbench

RX_FRAME_PARSER -- requirements
Module: rx_frame_parser

---
 rtl/rx_frame_parser.sv | 169 ++++++++++++++++
 tb/tb_rx_frame_parser.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rx_frame_parser.sv
// rx_frame_parser: byte-serial frame parser sitting behind a UART receiver.
// Frame: LEN, LEN data bytes, KLEN, KLEN key bytes [, checksum byte].
// Optional feature macro: RX_FRAME_CHECKSUM_EN adds a trailing XOR checksum
// byte covering LEN through the last key byte.
// A complete frame is held (frame_valid=1) until the consumer pulses consume;
// while held, the receiver is backpressured by keeping Rx_Ack low.
module rx_frame_parser #(
  parameter int MAX_DATA = 100,
  parameter int MAX_KEYS = 3
) (
  input  logic       Clk_100M,
  input  logic       Reset,
  input  logic [7:0] Rx_Data,
  input  logic       Rx_Ready,
  output logic       Rx_Ack,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  input  logic [1:0] key_addr,
  output logic [7:0] key_data,
  output logic [7:0] data_len,
  output logic [1:0] key_len,
  output logic       frame_valid,
  output logic       frame_error,
  input  logic       consume
);

  localparam logic [7:0] MAX_D8 = 8'(MAX_DATA);
  localparam logic [7:0] MAX_K8 = 8'(MAX_KEYS);

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_KLEN,
    S_KEY,
`ifdef RX_FRAME_CHECKSUM_EN
    S_CSUM,
`endif
    S_HOLD
  } state_t;

  state_t     r_state;
  logic [1:0] r_rst_sync;
  logic       w_rst_n;
  logic       r_ack;
  logic       r_fvalid;
  logic       r_err;
  logic [7:0] r_dlen;
  logic [1:0] r_klen;
  logic [7:0] r_dcnt;
  logic [1:0] r_kcnt;
`ifdef RX_FRAME_CHECKSUM_EN
  logic [7:0] r_csum;
`endif
  logic       w_accept;

  // Buffers are sized by the read-address widths so every address is in range.
  logic [7:0] r_dbuf [0:127];
  logic [7:0] r_kbuf [0:3];

  // Reset asserts asynchronously, releases two clocks after Reset goes high.
  always_ff @(posedge Clk_100M or negedge Reset) begin
    if (!Reset) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // One byte per Rx_Ready assertion; nothing is taken while a frame is held.
  assign w_accept = Rx_Ready && !r_ack && (r_state != S_HOLD);

  // Parser state machine, handshake and frame bookkeeping.
  always_ff @(posedge Clk_100M or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state  <= S_LEN;
      r_ack    <= 1'b0;
      r_fvalid <= 1'b0;
      r_err    <= 1'b0;
      r_dlen   <= 8'd0;
      r_klen   <= 2'd0;
      r_dcnt   <= 8'd0;
      r_kcnt   <= 2'd0;
`ifdef RX_FRAME_CHECKSUM_EN
      r_csum   <= 8'd0;
`endif
    end else begin
      r_err <= 1'b0;
      r_ack <= w_accept | (r_ack & Rx_Ready);
      case (r_state)
        S_LEN: if (w_accept) begin
          if (Rx_Data != 8'd0 && Rx_Data <= MAX_D8) begin
            r_dlen  <= Rx_Data;
            r_dcnt  <= 8'd0;
            r_state <= S_DATA;
`ifdef RX_FRAME_CHECKSUM_EN
            r_csum  <= Rx_Data;
`endif
          end else begin
            r_err <= 1'b1;
          end
        end
        S_DATA: if (w_accept) begin
          r_dcnt <= r_dcnt + 8'd1;
`ifdef RX_FRAME_CHECKSUM_EN
          r_csum <= r_csum ^ Rx_Data;
`endif
          if (r_dcnt + 8'd1 == r_dlen) r_state <= S_KLEN;
        end
        S_KLEN: if (w_accept) begin
          if (Rx_Data != 8'd0 && Rx_Data <= MAX_K8) begin
            r_klen  <= Rx_Data[1:0];
            r_kcnt  <= 2'd0;
            r_state <= S_KEY;
`ifdef RX_FRAME_CHECKSUM_EN
            r_csum  <= r_csum ^ Rx_Data;
`endif
          end else begin
            r_err   <= 1'b1;
            r_state <= S_LEN;
          end
        end
        S_KEY: if (w_accept) begin
          r_kcnt <= r_kcnt + 2'd1;
`ifdef RX_FRAME_CHECKSUM_EN
          r_csum <= r_csum ^ Rx_Data;
          if (r_kcnt + 2'd1 == r_klen) r_state <= S_CSUM;
`else
          if (r_kcnt + 2'd1 == r_klen) begin
            r_state  <= S_HOLD;
            r_fvalid <= 1'b1;
          end
`endif
        end
`ifdef RX_FRAME_CHECKSUM_EN
        S_CSUM: if (w_accept) begin
          if (Rx_Data == r_csum) begin
            r_state  <= S_HOLD;
            r_fvalid <= 1'b1;
          end else begin
            r_err   <= 1'b1;
            r_state <= S_LEN;
          end
        end
`endif
        S_HOLD: if (consume) begin
          r_state  <= S_LEN;
          r_fvalid <= 1'b0;
        end
        default: begin
          r_state  <= S_LEN;
          r_fvalid <= 1'b0;
        end
      endcase
    end
  end

  // Payload storage; never cleared, so stale bytes survive reset and errors.
  always_ff @(posedge Clk_100M) begin
    if (w_accept && r_state == S_DATA) r_dbuf[r_dcnt[6:0]] <= Rx_Data;
    if (w_accept && r_state == S_KEY)  r_kbuf[r_kcnt]      <= Rx_Data;
  end

  assign rd_data     = r_dbuf[rd_addr];
  assign key_data    = r_kbuf[key_addr];
  assign Rx_Ack      = r_ack;
  assign frame_valid = r_fvalid;
  assign frame_error = r_err;
  assign data_len    = r_dlen;
  assign key_len     = r_klen;

endmodule

// File: tb/tb_rx_frame_parser.sv
// Directed bench for rx_frame_parser in its default build (no checksum byte).
module tb_rx_frame_parser;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_ack;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic [1:0] key_addr;
  logic [7:0] key_data;
  logic [7:0] data_len;
  logic [1:0] key_len;
  logic       frame_valid;
  logic       frame_error;
  logic       consume;

  int total = 0;
  int bad   = 0;
  int n_err = 0;
  int err0;

  rx_frame_parser dut (
    .Clk_100M(clk), .Reset(rst_n), .Rx_Data(rx_data), .Rx_Ready(rx_ready),
    .Rx_Ack(rx_ack), .rd_addr(rd_addr), .rd_data(rd_data), .key_addr(key_addr),
    .key_data(key_data), .data_len(data_len), .key_len(key_len),
    .frame_valid(frame_valid), .frame_error(frame_error), .consume(consume)
  );

  always #5 clk = ~clk;

  // count cycles on which frame_error is high
  always @(negedge clk) if (frame_error) n_err++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte, wait for its acknowledge, then release the handshake.
  task automatic send_byte(input logic [7:0] b);
    bit got;
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (rx_ack) got = 1;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL ack_timeout observed=0 expected=1");
    end
    rx_ready = 1'b0;
    for (int i = 0; i < 20 && rx_ack; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_consume();
    @(negedge clk); consume = 1'b1;
    @(negedge clk); consume = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rx_data = 8'h00; rx_ready = 1'b0;
    rd_addr = 7'd0; key_addr = 2'd0; consume = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack",   {31'd0, rx_ack},      32'd0);
    check("rst_valid", {31'd0, frame_valid}, 32'd0);
    check("rst_error", {31'd0, frame_error}, 32'd0);
    check("rst_dlen",  {24'd0, data_len},    32'd0);
    check("rst_klen",  {30'd0, key_len},     32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // basic frame 03 41 42 43 02 10 20
    send_byte(8'h03); send_byte(8'h41); send_byte(8'h42); send_byte(8'h43);
    send_byte(8'h02); send_byte(8'h10); send_byte(8'h20);
    check("f1_valid", {31'd0, frame_valid}, 32'd1);
    check("f1_dlen",  {24'd0, data_len},    32'd3);
    check("f1_klen",  {30'd0, key_len},     32'd2);
    rd_addr = 7'd0; #1 check("f1_rd0", {24'd0, rd_data}, 32'h41);
    rd_addr = 7'd1; #1 check("f1_rd1", {24'd0, rd_data}, 32'h42);
    rd_addr = 7'd2; #1 check("f1_rd2", {24'd0, rd_data}, 32'h43);
    key_addr = 2'd0; #1 check("f1_k0", {24'd0, key_data}, 32'h10);
    key_addr = 2'd1; #1 check("f1_k1", {24'd0, key_data}, 32'h20);

    // backpressure: next LEN byte stalls while held
    @(negedge clk); rx_data = 8'h01; rx_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("bp_ack",   {31'd0, rx_ack},      32'd0);
    check("bp_valid", {31'd0, frame_valid}, 32'd1);
    consume = 1'b1;
    @(negedge clk); consume = 1'b0;
    check("bp_released", {31'd0, frame_valid}, 32'd0);
    @(posedge clk); #1;
    check("bp_ack_after_consume", {31'd0, rx_ack}, 32'd1);
    rx_ready = 1'b0;
    repeat (2) @(posedge clk);
    send_byte(8'h66); send_byte(8'h01); send_byte(8'h77);
    check("bp_valid2", {31'd0, frame_valid}, 32'd1);
    check("bp_dlen",   {24'd0, data_len},    32'd1);
    rd_addr = 7'd0; #1 check("bp_rd0", {24'd0, rd_data}, 32'h66);
    do_consume();

    // LEN=0 error, then frame 01 55 01 AA
    err0 = n_err;
    send_byte(8'h00);
    repeat (2) @(negedge clk);
    check("len0_err", n_err - err0, 32'd1);
    send_byte(8'h01); send_byte(8'h55); send_byte(8'h01); send_byte(8'hAA);
    check("len0_valid", {31'd0, frame_valid}, 32'd1);
    check("len0_dlen",  {24'd0, data_len},    32'd1);
    rd_addr = 7'd0; #1 check("len0_rd0", {24'd0, rd_data}, 32'h55);
    key_addr = 2'd0; #1 check("len0_k0", {24'd0, key_data}, 32'hAA);
    do_consume();

    // LEN above MAX_DATA (101) is rejected
    err0 = n_err;
    send_byte(8'h65);
    repeat (2) @(negedge clk);
    check("lenmax_err", n_err - err0, 32'd1);

    // KLEN=04 error returns to S_LEN
    err0 = n_err;
    send_byte(8'h02); send_byte(8'h01); send_byte(8'h02); send_byte(8'h04);
    repeat (2) @(negedge clk);
    check("klen4_err",   n_err - err0, 32'd1);
    check("klen4_valid", {31'd0, frame_valid}, 32'd0);
    // parser must be back in S_LEN: 01 33 01 44 forms a whole frame
    send_byte(8'h01); send_byte(8'h33); send_byte(8'h01); send_byte(8'h44);
    check("klen4_resync", {31'd0, frame_valid}, 32'd1);
    rd_addr = 7'd0; #1 check("klen4_rd0", {24'd0, rd_data}, 32'h33);
    do_consume();

    // boundary: LEN=100, KLEN=3
    send_byte(8'd100);
    for (int i = 0; i < 100; i++) send_byte(8'(i + 8'h80));
    send_byte(8'h03); send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3);
    check("max_valid", {31'd0, frame_valid}, 32'd1);
    check("max_dlen",  {24'd0, data_len},    32'd100);
    check("max_klen",  {30'd0, key_len},     32'd3);
    rd_addr = 7'd99; #1 check("max_rd99", {24'd0, rd_data}, 32'hE3);
    rd_addr = 7'd0;  #1 check("max_rd0",  {24'd0, rd_data}, 32'h80);
    key_addr = 2'd2; #1 check("max_k2",   {24'd0, key_data}, 32'hC3);
    do_consume();
    check("max_consumed", {31'd0, frame_valid}, 32'd0);

    // reset mid-frame: 05 11 22 then Reset low
    send_byte(8'h05); send_byte(8'h11); send_byte(8'h22);
    @(negedge clk); rst_n = 1'b0; #1;
    check("mid_rst_dlen",  {24'd0, data_len},    32'd0);
    check("mid_rst_klen",  {30'd0, key_len},     32'd0);
    check("mid_rst_valid", {31'd0, frame_valid}, 32'd0);
    check("mid_rst_ack",   {31'd0, rx_ack},      32'd0);
    check("mid_rst_err",   {31'd0, frame_error}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_byte(8'h02); send_byte(8'hAB); send_byte(8'hCD);
    send_byte(8'h01); send_byte(8'hEE);
    check("post_rst_valid", {31'd0, frame_valid}, 32'd1);
    check("post_rst_dlen",  {24'd0, data_len},    32'd2);
    check("post_rst_klen",  {30'd0, key_len},     32'd1);
    rd_addr = 7'd1;  #1 check("post_rst_rd1", {24'd0, rd_data},  32'hCD);
    key_addr = 2'd0; #1 check("post_rst_k0",  {24'd0, key_data}, 32'hEE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
